// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for serial_adder
package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder
// Ports: a, b (addend bits) -> s (sum bit), c (carry bit).
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - full adder cell built from two half adders
// Ports: a, b (addend bits), ci (carry in) -> s (sum bit), co (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    // The two half-adder carries can never both be set, so OR gives the carry.
    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Ports: clk, rst (sync, active-high); start, a, b, cin (request and operands);
//        busy, done (status); sum, cout (result, held until next accepted start);
//        ovf (signed overflow, only when SERIAL_ADDER_OVF_EN is defined).
// Macro: SERIAL_ADDER_OVF_EN enables the ovf output and its logic.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               load;
    logic               fa_s;
    logic               fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    full_adder u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // A start is honoured in IDLE and in DONE (back-to-back), never mid-shift.
    assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_co;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_SHIFT;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard testbench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, unsigned and two's-complement views.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t    e;
        longint  t;
        longint  sx;
        longint  sy;
        longint  ss;
        t  = longint'(x) + longint'(y) + longint'(ci);
        sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
        sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
        ss = sx + sy + longint'(ci);
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (ss > ((longint'(1) << (W-1)) - 1)) || (ss < -(longint'(1) << (W-1)));
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", longint'(sum), longint'(e.sum));
                check("cout", longint'(cout), longint'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", longint'(ovf), longint'(e.ovf));
`endif
            end
        end
    end

    // Drive a start for one cycle; the request is assumed accepted at the edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        @(negedge clk);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, ci));
        #1 start = 1'b0;
    endtask

    // Count edges and busy cycles until done, bounded.
    task automatic wait_done(output int lat, output int bcnt, output bit got);
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                if (busy) bcnt++;
                lat++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int lat;
        int bcnt;
        bit got;
        issue(x, y, ci);
        wait_done(lat, bcnt, got);
        if (got) begin
            check("latency_edges", longint'(lat + 1), longint'(W + 1));
            check("busy_cycles", longint'(bcnt), longint'(W));
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        bit got;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_sum", longint'(sum), 0);
        check("rst_cout", longint'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", longint'(ovf), 0);
`endif
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // A start while busy must be ignored.
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt, got);
        repeat (12) @(negedge clk);

        // Back-to-back: start held in the done cycle with new operands.
        issue(8'h11, 8'h22, 1'b0);
        repeat (W) @(posedge clk);
        #1;
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("b2b_done_cycle", longint'(done), 1);
        @(posedge clk);
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        #1 start = 1'b0;
        wait_done(lat, bcnt, got);
        if (got) check("b2b_latency_edges", longint'(lat + 1), longint'(W + 1));

        // Reset 4 cycles into an operation aborts it with no done.
        issue(8'h5A, 8'h33, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_sum", longint'(sum), 0);
        check("abort_cout", longint'(cout), 0);
        check("abort_done", longint'(done), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'h05, 8'h03, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         ci;
            x  = W'($urandom);
            y  = W'($urandom);
            ci = 1'($urandom);
            run_op(x, y, ci);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
